// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants (state encoding, parity types, default width) for the TX and RX paths.
// Optional feature macro: UART_TX_BREAK_EN adds the BREAK state encoding.
package uart_pkg;
    localparam int DEF_DATA_WIDTH = 8;
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD = 1'b1;
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP1 = 3'd4;
    localparam logic [2:0] ST_STOP_2 = 3'd5;
`ifdef UART_TX_BREAK_EN
    localparam logic [2:0] ST_BREAK = 3'd6;
`endif
    typedef enum logic [2:0] {
        IDLE = ST_IDLE,
        START = ST_START,
        DATA = ST_DATA,
        PARITY = ST_PARITY,
        STOP1 = ST_STOP1,
        STOP_2 = ST_STOP_2
`ifdef UART_TX_BREAK_EN
        , BREAK = ST_BREAK
`endif
    } uart_state_e;
endpackage

// File: rtl/uart_parity_calc.sv
// uart_parity_calc: parity bit of a data word, even or odd selected by PAR_TYP.
// Ports: data (word), PAR_TYP (0 even / 1 odd), par_bit (resulting parity bit).
module uart_parity_calc
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  PAR_TYP,
    output logic                  par_bit
);
    assign par_bit = (PAR_TYP == PAR_EVEN) ? ^data : ~^data;
endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmitter with one-entry holding buffer, runtime parity and 1/2 stop bits.
// Ports: CLK, RST (async active-low), TICK (baud strobe), P_DATA/DATA_VALID/DATA_READY (word handshake),
// PAR_EN/PAR_TYP/STOP2 (frame config, latched with the word), TX_OUT (registered serial line), Busy.
// Optional feature macro: UART_TX_BREAK_EN adds SEND_BREAK and a BREAK state.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  TICK,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    output logic                  DATA_READY,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
`ifdef UART_TX_BREAK_EN
    input  logic                  SEND_BREAK,
`endif
    output logic                  TX_OUT,
    output logic                  Busy
);
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
    uart_state_e state, nstate;
    logic hold_full, hold_pen, hold_par, hold_stop2;
    logic cur_pen, cur_par, cur_stop2;
    logic accept, xfer, par_calc, tx_next, tx_low;
    logic [DATA_WIDTH-1:0] hold_data, sh, sh_next;
    logic [CW-1:0] cnt;
`ifdef UART_TX_BREAK_EN
    localparam int BW = $clog2(DATA_WIDTH + 2);
    localparam logic [BW-1:0] BRK_LAST = BW'(DATA_WIDTH + 1);
    logic [BW-1:0] brk_cnt;
    logic brk_entry;
    assign brk_entry = nstate == BREAK && state != BREAK;
`endif
    assign DATA_READY = !hold_full;
    assign Busy = state != IDLE;
    assign accept = DATA_VALID && !hold_full;
    // START is only ever entered by moving the held word into the shift register
    assign xfer = nstate == START && state != START;
    assign sh_next = xfer ? hold_data : (TICK && state == DATA) ? sh >> 1 : sh;
    assign tx_low = nstate == START
`ifdef UART_TX_BREAK_EN
                    || nstate == BREAK
`endif
                    ;
    // line value is registered from the next state so each bit starts on the edge after its TICK
    assign tx_next = tx_low ? 1'b0 : nstate == DATA ? sh_next[0] : nstate == PARITY ? cur_par : 1'b1;
    uart_parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_par (
        .data(P_DATA),
        .PAR_TYP(PAR_TYP),
        .par_bit(par_calc)
    );
    always_comb begin
        nstate = state;
        if (TICK)
            case (state)
`ifdef UART_TX_BREAK_EN
                IDLE:    nstate = SEND_BREAK ? BREAK : hold_full ? START : IDLE;
                BREAK:   nstate = brk_cnt == BRK_LAST ? STOP1 : BREAK;
`else
                IDLE:    nstate = hold_full ? START : IDLE;
`endif
                START:   nstate = DATA;
                DATA:    nstate = cnt == LAST ? (cur_pen ? PARITY : STOP1) : DATA;
                PARITY:  nstate = STOP1;
                STOP1:   nstate = cur_stop2 ? STOP_2 : hold_full ? START : IDLE;
                STOP_2:  nstate = hold_full ? START : IDLE;
                default: nstate = IDLE;
            endcase
    end
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
            TX_OUT <= 1'b1;
            hold_full <= 1'b0;
            hold_data <= '0;
            hold_pen <= 1'b0;
            hold_par <= 1'b0;
            hold_stop2 <= 1'b0;
            cur_pen <= 1'b0;
            cur_par <= 1'b0;
            cur_stop2 <= 1'b0;
            sh <= '0;
            cnt <= '0;
`ifdef UART_TX_BREAK_EN
            brk_cnt <= '0;
`endif
        end else begin
            state <= nstate;
            TX_OUT <= tx_next;
            sh <= sh_next;
            hold_full <= accept || (hold_full && !xfer);
            if (accept) begin
                hold_data <= P_DATA;
                hold_pen <= PAR_EN;
                hold_par <= par_calc;
                hold_stop2 <= STOP2;
            end
            if (xfer) begin
                cur_pen <= hold_pen;
                cur_par <= hold_par;
                cur_stop2 <= hold_stop2;
            end
            cnt <= (nstate == DATA && state != DATA) ? '0 : (TICK && state == DATA) ? cnt + 1'b1 : cnt;
`ifdef UART_TX_BREAK_EN
            brk_cnt <= brk_entry ? '0 : (TICK && state == BREAK) ? brk_cnt + 1'b1 : brk_cnt;
            // a break always closes with a single stop bit
            if (brk_entry)
                cur_stop2 <= 1'b0;
`endif
        end
    end
endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

Parametrised UART transmit controller for the UART_TX path, covering the whole TX datapath in one block: start, data, parity and stop sequencing plus serialisation. It supports a configurable data width, runtime parity type and one or two stop bits. A one-entry holding buffer with a valid/ready handshake allows back-to-back frames. Bit timing comes from an external single-cycle baud strobe (TICK) supplied by the clock-divider block.

## Interface
- DATA_WIDTH, 8, data bits per frame, legal range 5..9
- CLK  in  1  system clock, all state on rising edge
- RST  in  1  asynchronous, active-low reset
- TICK  in  1  baud strobe, one CLK cycle wide, one per bit period
- P_DATA  in  DATA_WIDTH  parallel word to send
- DATA_VALID  in  1  P_DATA valid; accepted when DATA_READY=1 in the same cycle
- DATA_READY  out  1  holding buffer empty
- PAR_EN  in  1  1 = insert a parity bit
- PAR_TYP  in  1  0 = even parity, 1 = odd parity
- STOP2  in  1  1 = two stop bits, 0 = one stop bit
- TX_OUT  out  1  serial line, registered, idles high
- Busy  out  1  a frame is in progress (state != IDLE)
- Reset: one clock, asynchronous active-low RST, as decided.

## Operation
- Holding buffer: word accepted on DATA_VALID & DATA_READY. DATA_READY = !hold_full, which is combinational from the flag. A word offered while DATA_READY=0 is not taken, and the sender keeps DATA_VALID and P_DATA stable.
- Config latch: PAR_EN, PAR_TYP and STOP2 are captured with P_DATA at acceptance. Changes after acceptance do not affect that word's frame.
- Parity: the bit is XOR-reduce(data) for even and its inverse for odd. It is computed at acceptance.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP_2. All transitions happen only on cycles with TICK=1.
  - IDLE to START if hold_full. The buffer moves to the shift register and hold_full clears.
  - START to DATA.
  - DATA: shifts LSB first. When bit counter = DATA_WIDTH-1, go to PARITY if PAR_EN, else STOP1.
  - PARITY to STOP1.
  - STOP1 to STOP_2 if STOP2, else to the end-of-frame transition.
  - STOP_2 to the end-of-frame transition.
- End of frame: to START if hold_full (buffer transfer, no idle gap), else to IDLE.
- TX_OUT per state: IDLE 1, START 0, DATA the current LSB, PARITY the parity bit, STOP1/STOP_2 1.
- Bit counter: width $clog2(DATA_WIDTH). Cleared on entry to DATA, incremented per TICK in DATA.
- Data and config presented with no TICK: accepted, held, and no frame starts until the next TICK.

## Timing
- Reset values: TX_OUT=1, Busy=0, DATA_READY=1, state IDLE, hold_full=0, counter 0. Reset mid-frame aborts the frame, forces TX_OUT high immediately and discards the held word.
- TX_OUT, Busy and state update on the CLK edge following the TICK cycle, so each bit lasts exactly one TICK-to-TICK interval.
- Latency: the start bit appears on TX_OUT 1 CLK after the first TICK following acceptance.
- Frame length in TICKs: 1 + DATA_WIDTH + PAR_EN + 1 + STOP2.
- DATA_READY rises 1 CLK after the buffer transfer. A new word accepted before the last stop TICK is sent back-to-back.
- DATA_VALID in the same cycle as a transfer is not accepted, because hold_full is still 1 in that cycle.

## Configuration
- UART_TX_BREAK_EN defined: adds input SEND_BREAK (1 bit) and a BREAK state.
  - In IDLE, on a TICK with SEND_BREAK=1, go to BREAK. This has priority over a held word.
  - BREAK drives TX_OUT=0 for DATA_WIDTH+2 TICKs, then goes to STOP1 with one stop bit. Busy=1 throughout.
  - The held word is preserved and sent afterwards.
- UART_TX_BREAK_EN undefined: no SEND_BREAK port and no BREAK state. The FSM is exactly the six states above.

## Structure
- Shared package uart_pkg holds:
  - state encoding localparams (3-bit)
  - PAR_EVEN/PAR_ODD constants
  - the default DATA_WIDTH
- uart_rx reuses the same package.
- Sub-module uart_parity_calc: parametrised DATA_WIDTH, inputs data and PAR_TYP, output the parity bit. It is shared with the RX parity checker.
- The FSM, buffer and shift register stay in the top module.

## Test plan
- Reset, then 0xA5 with PAR_EN=1, PAR_TYP=0, STOP2=0 -> TX_OUT 0,1,0,1,0,0,1,0,1,0,1 over 11 TICKs; Busy high for exactly those 11 bit periods.
- 0xA5 with PAR_TYP=1, STOP2=1 -> parity bit 1, then two stop bits of 1; 12 TICKs.
- 0x3C then 0xFF, the second offered while the first is transmitting -> second start bit directly follows the first frame's stop bit; DATA_READY low from acceptance of 0xFF until its transfer.
- DATA_WIDTH=7, PAR_EN=0, 0x55 -> 9 TICKs, 7 data bits 1,0,1,0,1,0,1.
- RST asserted during DATA -> TX_OUT=1, Busy=0, DATA_READY=1 asynchronously; the next word sends a clean frame.
- With UART_TX_BREAK_EN: SEND_BREAK plus a held 0x81 -> TX_OUT low for 10 TICKs, 1 stop TICK, then the 0x81 frame.
